// File: rtl/tm1638_pkg.sv
// Shared constants and FSM state type for the TM1638 receiver.
// Command codes select how the first byte of a frame is decoded.
package tm1638_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int NUM_LEDS   = 8;

    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_DISP = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

endpackage

// File: rtl/tm1638_sync.sv
// Synchronizers for the TM1638 serial pins plus edge detection.
// Flops reset high (bus idle); ready marks when real pin values emerge.
module tm1638_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tm_clk,
    input  logic tm_stb,
    input  logic tm_dio,
    output logic clk_rise,
    output logic stb_rise,
    output logic stb_fall,
    output logic stb_lvl,
    output logic dio,
    output logic ready
);

    logic [SYNC_STAGES:0]   clk_sr;
    logic [SYNC_STAGES:0]   stb_sr;
    logic [SYNC_STAGES-1:0] dio_sr;
    logic [SYNC_STAGES-1:0] rdy_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sr <= '1;
            stb_sr <= '1;
            dio_sr <= '1;
            rdy_sr <= '0;
        end else begin
            clk_sr <= {clk_sr[SYNC_STAGES-1:0], tm_clk};
            stb_sr <= {stb_sr[SYNC_STAGES-1:0], tm_stb};
            dio_sr <= {dio_sr[SYNC_STAGES-2:0], tm_dio};
            rdy_sr <= {rdy_sr[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign clk_rise = clk_sr[SYNC_STAGES-1] & ~clk_sr[SYNC_STAGES];
    assign stb_rise = stb_sr[SYNC_STAGES-1] & ~stb_sr[SYNC_STAGES];
    assign stb_fall = ~stb_sr[SYNC_STAGES-1] & stb_sr[SYNC_STAGES];
    assign stb_lvl  = stb_sr[SYNC_STAGES-1];
    assign dio      = dio_sr[SYNC_STAGES-1];
    assign ready    = rdy_sr[SYNC_STAGES-1];

endmodule

// File: rtl/tm1638_rx.sv
// TM1638 slave receiver: decodes frames into digit/LED/display registers.
// Define TM1638_RX_LED_EN to keep the discrete LED register.
module tm1638_rx
    import tm1638_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       _50MHz_CLK,
    input  logic       rst_n,
    input  logic       tm_clk,
    input  logic       tm_stb,
    input  logic       tm_dio,
    output logic [7:0] LED7SEG_0,
    output logic [7:0] LED7SEG_1,
    output logic [7:0] LED7SEG_2,
    output logic [7:0] LED7SEG_3,
    output logic [7:0] LED7SEG_4,
    output logic [7:0] LED7SEG_5,
    output logic [7:0] LED7SEG_6,
    output logic [7:0] LED7SEG_7,
    output logic [7:0] leds,
    output logic       disp_on,
    output logic [2:0] brightness,
    output logic       frame_done,
    output logic       cmd_err
);

    logic clk_rise, stb_rise, stb_fall, stb_lvl, dio, ready;

    tm1638_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (_50MHz_CLK),
        .rst_n    (rst_n),
        .tm_clk   (tm_clk),
        .tm_stb   (tm_stb),
        .tm_dio   (tm_dio),
        .clk_rise (clk_rise),
        .stb_rise (stb_rise),
        .stb_fall (stb_fall),
        .stb_lvl  (stb_lvl),
        .dio      (dio),
        .ready    (ready)
    );

    state_t     state, state_n;
    logic [6:0] shreg;
    logic [2:0] bitcnt;
    logic [3:0] addr;
    logic       fixed;
    logic       armed;
    logic       got_byte;
    logic [7:0] seg [NUM_DIGITS];

    logic       start, sample, byte_done;
    logic [7:0] new_byte;
    logic       done_n, err_n;
    logic       set_mode, set_disp, set_addr, wr_data;

    // A frame only starts once stb has been seen high after reset.
    assign start     = stb_fall & armed;
    assign sample    = clk_rise & ~stb_rise & ~start & (state != IDLE);
    assign byte_done = sample & (bitcnt == 3'd7);
    assign new_byte  = {dio, shreg};

    always_comb begin
        state_n  = state;
        done_n   = 1'b0;
        err_n    = 1'b0;
        set_mode = 1'b0;
        set_disp = 1'b0;
        set_addr = 1'b0;
        wr_data  = 1'b0;
        if (stb_rise) begin
            state_n = IDLE;
            done_n  = (state != IDLE) & got_byte & (bitcnt == 3'd0);
        end else if (start) begin
            state_n = CMD;
        end else if (byte_done) begin
            if (state == DATA) begin
                wr_data = 1'b1;
            end else begin
                unique case (1'b1)
                    (new_byte[7:6] == CMD_DATA) &&
                    (new_byte[1:0] == 2'b00): set_mode = 1'b1;
                    (new_byte[7:6] == CMD_DISP): set_disp = 1'b1;
                    (new_byte[7:6] == CMD_ADDR): begin
                        set_addr = 1'b1;
                        state_n  = DATA;
                    end
                    default: begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge _50MHz_CLK or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

`ifdef TM1638_RX_LED_EN
    logic [7:0] leds_r;
    always_ff @(posedge _50MHz_CLK or negedge rst_n) begin
        if (!rst_n)                  leds_r <= 8'h00;
        else if (wr_data & addr[0])  leds_r[addr[3:1]] <= new_byte[0];
    end
    assign leds = leds_r;
`else
    assign leds = 8'h00;
`endif

    always_ff @(posedge _50MHz_CLK or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            bitcnt     <= '0;
            addr       <= '0;
            fixed      <= 1'b0;
            armed      <= 1'b0;
            got_byte   <= 1'b0;
            disp_on    <= 1'b0;
            brightness <= '0;
            frame_done <= 1'b0;
            cmd_err    <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) seg[i] <= 8'h00;
        end else begin
            frame_done <= done_n;
            cmd_err    <= err_n;
            if (ready & stb_lvl) armed <= 1'b1;
            if (stb_rise | start) begin
                shreg  <= '0;
                bitcnt <= '0;
            end else if (sample) begin
                shreg  <= new_byte[7:1];
                bitcnt <= bitcnt + 3'd1;
            end
            if (start)          got_byte <= 1'b0;
            else if (byte_done) got_byte <= 1'b1;
            if (set_mode) fixed <= new_byte[2];
            if (set_disp) begin
                disp_on    <= new_byte[3];
                brightness <= new_byte[2:0];
            end
            if (set_addr)               addr <= new_byte[3:0];
            else if (wr_data & ~fixed)  addr <= addr + 4'd1;
            if (wr_data & ~addr[0]) seg[addr[3:1]] <= new_byte;
        end
    end

    assign LED7SEG_0 = seg[0];
    assign LED7SEG_1 = seg[1];
    assign LED7SEG_2 = seg[2];
    assign LED7SEG_3 = seg[3];
    assign LED7SEG_4 = seg[4];
    assign LED7SEG_5 = seg[5];
    assign LED7SEG_6 = seg[6];
    assign LED7SEG_7 = seg[7];

endmodule

// File: tb/tb_tm1638_rx.sv
// Bench for tm1638_rx: directed frames plus random frames vs a frame-level model.
module tb_tm1638_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tm_clk = 1'b1;
    logic       tm_stb = 1'b1;
    logic       tm_dio = 1'b1;
    logic [7:0] s0, s1, s2, s3, s4, s5, s6, s7;
    logic [7:0] leds;
    logic       disp_on;
    logic [2:0] brightness;
    logic       frame_done, cmd_err;
    logic [7:0] seg_d [8];

    always #10 clk = ~clk;

    tm1638_rx dut (
        ._50MHz_CLK (clk),
        .rst_n      (rst_n),
        .tm_clk     (tm_clk),
        .tm_stb     (tm_stb),
        .tm_dio     (tm_dio),
        .LED7SEG_0  (s0),
        .LED7SEG_1  (s1),
        .LED7SEG_2  (s2),
        .LED7SEG_3  (s3),
        .LED7SEG_4  (s4),
        .LED7SEG_5  (s5),
        .LED7SEG_6  (s6),
        .LED7SEG_7  (s7),
        .leds       (leds),
        .disp_on    (disp_on),
        .brightness (brightness),
        .frame_done (frame_done),
        .cmd_err    (cmd_err)
    );

    always_comb begin
        seg_d[0] = s0; seg_d[1] = s1; seg_d[2] = s2; seg_d[3] = s3;
        seg_d[4] = s4; seg_d[5] = s5; seg_d[6] = s6; seg_d[7] = s7;
    end

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Frame-level model: mode 0 = command byte, 1 = data bytes, 2 = ignoring.
    logic [7:0] m_seg [8];
    logic [7:0] m_leds;
    logic       m_disp;
    logic [2:0] m_bri;
    int         m_addr, m_fixed, m_mode, m_nb;
    int         exp_fd = 0, exp_err = 0, fd_cnt = 0, err_cnt = 0;
    bit         stable = 0;
    logic [7:0] fq [$];

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_seg[i] = 8'h00;
        m_leds = 8'h00; m_disp = 1'b0; m_bri = 3'd0;
        m_addr = 0; m_fixed = 0; m_mode = 2; m_nb = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        m_nb++;
        if (m_mode == 1) begin
            if (m_addr % 2 == 0) m_seg[m_addr / 2] = b;
`ifdef TM1638_RX_LED_EN
            else m_leds[m_addr / 2] = b[0];
`endif
            if (m_fixed == 0) m_addr = (m_addr + 1) % 16;
        end else if (m_mode == 0) begin
            if (b[7:6] == 2'b01 && b[1:0] == 2'b00) m_fixed = int'(b[2]);
            else if (b[7:6] == 2'b10) begin
                m_disp = b[3]; m_bri = b[2:0];
            end else if (b[7:6] == 2'b11) begin
                m_addr = int'(b[3:0]); m_mode = 1;
            end else begin
                exp_err++; m_mode = 2;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (cmd_err) err_cnt++;
    end

    always @(negedge clk) begin
        if (stable) begin
            for (int i = 0; i < 8; i++) chk($sformatf("seg%0d", i), 32'(seg_d[i]), 32'(m_seg[i]));
            chk("leds", 32'(leds), 32'(m_leds));
            chk("disp_on", 32'(disp_on), 32'(m_disp));
            chk("brightness", 32'(brightness), 32'(m_bri));
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic add(input logic [7:0] b);
        fq.push_back(b);
    endtask

    task automatic stb_low();
        tm_stb = 1'b0; m_mode = 0; m_nb = 0;
        wait_cyc(4);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            tm_clk = 1'b0; tm_dio = b[i];
            wait_cyc(4);
            if (i == 7) stable = 0;
            tm_clk = 1'b1;
            if (i == 7) begin
                wait_cyc(8); model_byte(b); stable = 1;
            end else wait_cyc(4);
        end
    endtask

    task automatic stb_high(input bit partial);
        wait_cyc(2);
        tm_stb = 1'b1;
        wait_cyc(12);
        if (m_mode != 2 && m_nb > 0 && !partial) exp_fd++;
        m_mode = 2;
        chk("frame_done_count", fd_cnt, exp_fd);
        chk("cmd_err_count", err_cnt, exp_err);
    endtask

    task automatic frame(input int pbits, input logic [7:0] pb);
        stb_low();
        foreach (fq[i]) send_bits(fq[i], 8);
        if (pbits > 0) send_bits(pb, pbits);
        stb_high(pbits > 0);
        fq.delete();
    endtask

    initial begin
        #3000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int fd0, err0, kind, nb, pbits;
        logic [7:0] b;
        model_reset();
        wait_cyc(3);
        chk("rst_seg0", 32'(s0), 0);
        chk("rst_leds", 32'(leds), 0);
        chk("rst_disp", 32'(disp_on), 0);
        chk("rst_bri", 32'(brightness), 0);
        chk("rst_fd", 32'(frame_done), 0);
        chk("rst_err", 32'(cmd_err), 0);
        rst_n = 1'b1;
        stable = 1;
        wait_cyc(10);

        add(8'h40); frame(0, 0);
        add(8'hC0); add(8'hDA); add(8'h00); add(8'hB7); add(8'h00); frame(0, 0);
        chk("r27_seg0", 32'(s0), 32'h DA);
        chk("r27_seg1", 32'(s1), 32'h B7);
        chk("r27_seg2", 32'(s2), 0);
        chk("r27_model", 32'(m_seg[1]), 32'h B7);
        chk("r27_fd", fd_cnt, 2);

        add(8'h44); frame(0, 0);
        add(8'hC6); add(8'hFA); add(8'h11); frame(0, 0);
        chk("r28_seg3", 32'(s3), 32'h11);
        chk("r28_seg4", 32'(s4), 0);
        chk("r28_leds", 32'(leds), 0);
        chk("r28_maddr", m_addr, 6);

        add(8'h40); frame(0, 0);
        add(8'hCF); add(8'h01); add(8'h5A); frame(0, 0);
        chk("r29_seg0", 32'(s0), 32'h5A);
`ifdef TM1638_RX_LED_EN
        chk("r29_leds", 32'(leds), 32'h80);
`else
        chk("r29_leds", 32'(leds), 32'h00);
`endif

        add(8'h8C); frame(0, 0);
        chk("r30_disp", 32'(disp_on), 1);
        chk("r30_bri", 32'(brightness), 4);
        fd0 = fd_cnt; err0 = err_cnt;
        add(8'h42); frame(0, 0);
        chk("r30_err", err_cnt - err0, 1);
        chk("r30_nofd", fd_cnt - fd0, 0);
        chk("r30_disp_kept", 32'(disp_on), 1);

        fd0 = fd_cnt;
        add(8'hC2); frame(5, 8'hAB);
        chk("r31_nofd", fd_cnt - fd0, 0);
        chk("r31_seg1", 32'(s1), 32'hB7);
        add(8'hC2); add(8'h33); frame(0, 0);
        chk("r31_seg1_new", 32'(s1), 32'h33);
        chk("r31_fd", fd_cnt - fd0, 1);

        stb_low();
        send_bits(8'hC0, 8);
        send_bits(8'h99, 3);
        stable = 0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("r32_seg0", 32'(s0), 0);
        chk("r32_seg1", 32'(s1), 0);
        chk("r32_seg3", 32'(s3), 0);
        chk("r32_leds", 32'(leds), 0);
        chk("r32_disp", 32'(disp_on), 0);
        chk("r32_bri", 32'(brightness), 0);
        wait_cyc(3);
        rst_n = 1'b1;
        stable = 1;
        send_bits(8'h55, 8);
        send_bits(8'hC0, 8);
        send_bits(8'h66, 8);
        stb_high(0);
        chk("r32_ignored", 32'(s0), 0);
        add(8'hC0); add(8'h77); frame(0, 0);
        chk("r32_next", 32'(s0), 32'h77);

        repeat (40) begin
            kind = $urandom_range(0, 3);
            pbits = 0;
            b = 8'($urandom);
            if (kind == 0) add(b);
            else if (kind == 1) add(8'h40 | (b & 8'h04) | ($urandom_range(0, 3) == 0 ? (b & 8'h03) : 8'h00));
            else if (kind == 2) add(8'h80 | (b & 8'h0F));
            else begin
                add(8'hC0 | (b & 8'h0F));
                nb = $urandom_range(1, 5);
                for (int i = 0; i < nb; i++) add(8'($urandom));
                if ($urandom_range(0, 3) == 0) pbits = $urandom_range(1, 7);
            end
            frame(pbits, 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
